// File: rtl/inst_encoder.sv
// Encodes field-level commands into RV32I instruction words, expanding LI into one or two words.
// Registered output, one-cycle latency; valid/ready with combinational cmd_ready_o for 1 word/cycle streaming.
module inst_encoder (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [3:0]  cmd_kind_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] imm_i,
    input  logic [11:0] csr_addr_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic        inst_last_o,
    output logic        e_illegal_cmd_o
);

    localparam logic [3:0] K_LUI = 4'd0, K_AUIPC = 4'd1, K_JAL = 4'd2, K_JALR = 4'd3,
                           K_BRANCH = 4'd4, K_LOAD = 4'd5, K_STORE = 4'd6, K_OPIMM = 4'd7,
                           K_OP = 4'd8, K_FENCE = 4'd9, K_SYSTEM = 4'd10, K_LI = 4'd11,
                           K_NOP = 4'd12;

    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                           OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
                           OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011,
                           OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {S_IDLE, S_OUT_LAST, S_OUT_FIRST} state_t;

    state_t      state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pend_q, pend_d;
    logic        illegal_q, illegal_d;

    logic [31:0] enc_word1, enc_word2, li_sum;
    logic        enc_two, enc_illegal;
    logic        i_ok, j_ok, b_ok, accept;

    // Range checks: upper bits must be a pure sign extension of the encodable field.
    assign i_ok   = (&imm_i[31:11]) || !(|imm_i[31:11]);
    assign j_ok   = (&imm_i[31:20]) || !(|imm_i[31:20]);
    assign b_ok   = (&imm_i[31:12]) || !(|imm_i[31:12]);
    assign li_sum = imm_i + 32'h0000_0800;

    always_comb begin
        enc_word1   = 32'h0;
        enc_word2   = 32'h0;
        enc_two     = 1'b0;
        enc_illegal = 1'b0;
        case (cmd_kind_i)
            K_LUI, K_AUIPC: begin
                enc_word1   = {imm_i[31:12], rd_i, (cmd_kind_i == K_LUI) ? OPC_LUI : OPC_AUIPC};
                enc_illegal = |imm_i[11:0];
            end
            K_JAL: begin
                enc_word1   = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
                enc_illegal = imm_i[0] || !j_ok;
            end
            K_BRANCH: begin
                enc_word1   = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], OPC_BRANCH};
                enc_illegal = imm_i[0] || !b_ok || (funct3_i == 3'b010) || (funct3_i == 3'b011);
            end
            K_JALR: begin
                enc_word1   = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_JALR};
                enc_illegal = !i_ok || (funct3_i != 3'b000);
            end
            K_LOAD: begin
                enc_word1   = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_LOAD};
                enc_illegal = !i_ok || (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
            end
            K_STORE: begin
                enc_word1   = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_STORE};
                enc_illegal = !i_ok || (funct3_i > 3'b010);
            end
            K_OPIMM: begin
                if (funct3_i == 3'b001 || funct3_i == 3'b101) begin
                    enc_word1   = {1'b0, funct7b5_i, 5'b0, imm_i[4:0], rs1_i, funct3_i, rd_i, OPC_OPIMM};
                    enc_illegal = (funct3_i == 3'b001) && funct7b5_i;
                end else begin
                    enc_word1   = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_OPIMM};
                    enc_illegal = !i_ok;
                end
            end
            K_OP: begin
                enc_word1   = {1'b0, funct7b5_i, 5'b0, rs2_i, rs1_i, funct3_i, rd_i, OPC_OP};
                enc_illegal = funct7b5_i && (funct3_i != 3'b000) && (funct3_i != 3'b101);
            end
            K_FENCE: enc_word1 = 32'h0FF0_000F;
            K_NOP:   enc_word1 = 32'h0000_0013;
            K_SYSTEM: begin
                if (funct3_i == 3'b000) begin
                    enc_word1   = {csr_addr_i, 5'b0, 3'b000, 5'b0, OPC_SYSTEM};
                    enc_illegal = (csr_addr_i != 12'h000) && (csr_addr_i != 12'h001) && (csr_addr_i != 12'h302);
                end else begin
                    enc_word1   = {csr_addr_i, rs1_i, funct3_i, rd_i, OPC_SYSTEM};
                    enc_illegal = (funct3_i == 3'b100);
                end
            end
            K_LI: begin
                if (i_ok) begin
                    enc_word1 = {imm_i[11:0], 5'b0, 3'b000, rd_i, OPC_OPIMM};
                end else begin
                    enc_word1 = {li_sum[31:12], rd_i, OPC_LUI};
                    enc_word2 = {imm_i[11:0], rd_i, 3'b000, rd_i, OPC_OPIMM};
                    enc_two   = |imm_i[11:0];
                end
            end
            default: enc_illegal = 1'b1;
        endcase
    end

    assign inst_valid_o    = (state_q != S_IDLE);
    assign inst_last_o     = (state_q == S_OUT_LAST);
    assign inst_o          = inst_q;
    assign e_illegal_cmd_o = illegal_q;
    assign cmd_ready_o     = !inst_valid_o || (inst_last_o && inst_ready_i);
    assign accept          = cmd_valid_i && cmd_ready_o;

    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        pend_d    = pend_q;
        illegal_d = 1'b0;
        if (state_q == S_OUT_FIRST && inst_ready_i) begin
            state_d = S_OUT_LAST;
            inst_d  = pend_q;
        end else if (accept) begin
            if (enc_illegal) begin
                state_d   = S_IDLE;
                illegal_d = 1'b1;
            end else begin
                state_d = enc_two ? S_OUT_FIRST : S_OUT_LAST;
                inst_d  = enc_word1;
                pend_d  = enc_word2;
            end
        end else if (state_q == S_OUT_LAST && inst_ready_i) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            inst_q    <= 32'h0;
            pend_q    <= 32'h0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            pend_q    <= pend_d;
            illegal_q <= illegal_d;
        end
    end

endmodule
